// File: rtl/cpu_pkg.sv
// Shared types for the trace data memory: FSM states,
// log-entry layout and the byte-lane merge helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  localparam int LOG_ENTRY_W = $bits(log_entry_t);

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/trace_dmem_if.sv
// Request/response bus and write-log port of trace_dmem.
// slave = memory side, master = requester side.
interface trace_dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_byteen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  modport slave (
    input  req_valid, req_byteen, req_addr,
    input  req_wdata, req_pc, log_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, log_valid, log_pc,
    output log_addr, log_data, log_overflow
  );

  modport master (
    output req_valid, req_byteen, req_addr,
    output req_wdata, req_pc, log_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, log_valid, log_pc,
    input  log_addr, log_data, log_overflow
  );

endinterface

// File: rtl/trace_fifo.sv
// Write-log FIFO with an occupancy counter and a sticky
// overflow flag; a push into a full FIFO survives a same-cycle pop.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = i_ready & ~w_empty;
  assign w_wr    = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
      if (i_push & ~w_wr) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wr] <= i_data;
  end

  assign o_valid    = ~w_empty;
  assign o_data     = r_buf[r_rd];
  assign o_overflow = r_ovf;

endmodule

// File: rtl/trace_dmem.sv
// Wait-stated word memory that zeroes itself after reset and
// logs every in-range write (pc, address, merged word).
import cpu_pkg::*;

module trace_dmem #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0,
  parameter int LOG_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  trace_dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_INIT =
    3'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  dmem_state_e r_state;
  dmem_state_e w_next;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [AW-1:0] r_clr_idx;
  logic [2:0]    r_wait_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_ready;
  logic          w_rsp;
  logic          w_clr_we;
  logic          w_accept;
  logic          w_mem_we;
  logic [31:0]   w_waddr;
  logic          w_in_range;
  logic          w_is_wr;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  log_entry_t    w_entry;
  log_entry_t    w_head;

  assign w_waddr    = bus.req_addr & 32'hFFFF_FFFC;
  assign w_in_range = (w_waddr[31:2] < 30'(DEPTH_WORDS));
  assign w_idx      = w_waddr[AW+1:2];
  assign w_is_wr    = |bus.req_byteen;
  assign w_old      = r_mem[w_idx];
  assign w_merged   =
    merge_bytes(w_old, bus.req_wdata, bus.req_byteen);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_rsp    = 1'b0;
    w_clr_we = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_idx == AW'(DEPTH_WORDS - 1))
          w_next = S_IDLE;
      end
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid)
          w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  assign w_accept = w_ready & bus.req_valid;
  assign w_mem_we = w_accept & w_is_wr & w_in_range;

  always_ff @(posedge clk) begin
    if (w_clr_we)      r_mem[r_clr_idx] <= '0;
    else if (w_mem_we) r_mem[w_idx]     <= w_merged;
  end

  // Response is resolved at acceptance; memory is idle until RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_idx  <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_clr_we) r_clr_idx <= r_clr_idx + 1'b1;
      if (w_accept) begin
        r_wait_cnt <= WAIT_INIT;
        r_err      <= ~w_in_range;
        if (!w_in_range) r_rdata <= '0;
        else if (w_is_wr) r_rdata <= w_merged;
        else r_rdata <= w_old;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_rdata = w_rsp ? r_rdata : '0;
  assign bus.rsp_err   = w_rsp & r_err;

  assign w_entry = '{
    pc:   bus.req_pc,
    addr: w_waddr,
    data: w_merged
  };

  trace_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LOG_ENTRY_W)
  ) u_log (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_mem_we),
    .i_data     (w_entry),
    .i_ready    (bus.log_ready),
    .o_valid    (bus.log_valid),
    .o_data     (w_head),
    .o_overflow (bus.log_overflow)
  );

  assign bus.log_pc   = w_head.pc;
  assign bus.log_addr = w_head.addr;
  assign bus.log_data = w_head.data;

endmodule

// File: tb/tb_trace_dmem.sv
// Directed + random bench for trace_dmem against a
// transaction-level memory/log model.
module tb_trace_dmem;
  import cpu_pkg::*;

  localparam int DW = 16;
  localparam int WC = 3;
  localparam int LD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  trace_dmem_if bus ();

  trace_dmem #(
    .DEPTH_WORDS (DW),
    .WAIT_CYCLES (WC),
    .LOG_DEPTH   (LD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [DW];
  log_entry_t  log_q [$];
  bit          ovf_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    if (be[0]) m = m | 32'h0000_00FF;
    if (be[1]) m = m | 32'h0000_FF00;
    if (be[2]) m = m | 32'h00FF_0000;
    if (be[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  task automatic check_log_status();
    check("log_valid", 32'(bus.log_valid),
          32'(log_q.size() > 0));
    check("log_ovf", 32'(bus.log_overflow), 32'(ovf_m));
  endtask

  task automatic model_reset();
    log_q.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < DW; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic sweep_check();
    for (int i = 0; i < DW; i++) begin
      check("sweep_busy", 32'(bus.req_ready), 32'h0);
      step();
    end
    check("sweep_done", 32'(bus.req_ready), 32'h1);
  endtask

  task automatic scramble();
    bus.req_byteen = 4'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_pc     = $urandom;
  endtask

  task automatic do_req(input logic [3:0]  be,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] pc,
                        input bit          pop);
    logic [31:0] wi;
    logic [31:0] exp_d;
    logic [31:0] m;
    bit          exp_err;
    bit          got;
    log_entry_t  e;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("ready_wait", 32'(got), 32'h1);
    if (!got) return;
    bus.req_valid  = 1'b1;
    bus.req_byteen = be;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_pc     = pc;
    bus.log_ready  = pop;
    wi      = addr >> 2;
    exp_err = (wi >= DW);
    if (exp_err) exp_d = 32'h0;
    else if (be == 4'h0) exp_d = ref_mem[wi];
    else begin
      m     = mask_of(be);
      exp_d = (ref_mem[wi] & ~m) | (wd & m);
    end
    if (pop && log_q.size() > 0)
      check("pop_pc", bus.log_pc, log_q[0].pc);
    step();
    if (pop && log_q.size() > 0) void'(log_q.pop_front());
    if (!exp_err && be != 4'h0) begin
      ref_mem[wi] = exp_d;
      e.pc   = pc;
      e.addr = wi << 2;
      e.data = exp_d;
      if (log_q.size() < LD) log_q.push_back(e);
      else ovf_m = 1'b1;
    end
    bus.req_valid = 1'b0;
    bus.log_ready = 1'b0;
    scramble();
    for (int k = 1; k <= WC + 1; k++) begin
      check("rsp_valid", 32'(bus.rsp_valid),
            32'(k == WC + 1));
      check("busy", 32'(bus.req_ready), 32'h0);
      if (k == WC + 1) begin
        check("rdata", bus.rsp_rdata, exp_d);
        check("err", 32'(bus.rsp_err), 32'(exp_err));
      end
      step();
    end
    check("rsp_end", 32'(bus.rsp_valid), 32'h0);
    check("ready_again", 32'(bus.req_ready), 32'h1);
    check_log_status();
  endtask

  task automatic drain(input int n);
    bus.log_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 32'(bus.log_valid),
            32'(log_q.size() > 0));
      if (log_q.size() > 0) begin
        check("log_pc", bus.log_pc, log_q[0].pc);
        check("log_addr", bus.log_addr, log_q[0].addr);
        check("log_data", bus.log_data, log_q[0].data);
      end
      step();
      if (log_q.size() > 0) void'(log_q.pop_front());
    end
    bus.log_ready = 1'b0;
    check_log_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  be;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.log_ready = 1'b0;
    scramble();
    model_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rvalid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_err", 32'(bus.rsp_err), 32'h0);
    check_log_status();
    reset = 1'b0;
    sweep_check();

    do_req(4'h0, 32'h8, 32'h0, 32'h100, 1'b0);
    do_req(4'hF, 32'h10, 32'hDEADBEEF, 32'h104, 1'b0);
    do_req(4'h5, 32'h12, 32'h11223344, 32'h108, 1'b0);
    do_req(4'h0, 32'h10, 32'h0, 32'h10C, 1'b0);
    drain(3);

    do_req(4'hF, 32'h40, 32'hCAFEF00D, 32'h110, 1'b0);
    do_req(4'hF, 32'h4000, 32'h12345678, 32'h114, 1'b0);
    do_req(4'h0, 32'h0, 32'h0, 32'h118, 1'b0);
    do_req(4'hF, 32'h3C, 32'hA5A5A5A5, 32'h11C, 1'b0);
    do_req(4'h0, 32'h3C, 32'h0, 32'h120, 1'b0);
    drain(2);

    do_req(4'hF, 32'h4, 32'h01010101, 32'h200, 1'b0);
    do_req(4'h3, 32'h8, 32'h02020202, 32'h204, 1'b0);
    do_req(4'hC, 32'hC, 32'h03030303, 32'h208, 1'b0);
    do_req(4'h1, 32'h14, 32'h04040404, 32'h20C, 1'b1);
    drain(3);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) == 0) be = 4'h0;
      else be = 4'($urandom);
      a = ($urandom_range(0, 19) << 2) | ($urandom & 3);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      do_req(be, a, $urandom, $urandom,
             bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        drain($urandom_range(1, 3));
    end

    drain(3);
    do_req(4'hF, 32'h20, 32'h77777777, 32'h300, 1'b0);
    do_req(4'hF, 32'h24, 32'h88888888, 32'h304, 1'b0);
    do_req(4'hF, 32'h28, 32'h99999999, 32'h308, 1'b0);
    while (!bus.req_ready) step();
    bus.req_valid  = 1'b1;
    bus.req_byteen = 4'hF;
    bus.req_addr   = 32'h2C;
    bus.req_wdata  = 32'h5555AAAA;
    bus.req_pc     = 32'h400;
    step();
    bus.req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < WC + 2; k++) begin
      check("midrst_rvalid", 32'(bus.rsp_valid), 32'h0);
      check("midrst_logv", 32'(bus.log_valid), 32'h0);
      check("midrst_ovf", 32'(bus.log_overflow), 32'h0);
      check("midrst_ready", 32'(bus.req_ready), 32'h0);
      step();
    end
    reset = 1'b0;
    model_reset();
    sweep_check();
    do_req(4'h0, 32'h2C, 32'h0, 32'h500, 1'b0);
    do_req(4'h0, 32'h20, 32'h0, 32'h504, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
